// File: rtl/puf_crp_sampler.sv
// Challenge/response sequencer around the ROPUF core: latches a challenge, settles, samples SAMPLES times, majority-votes.
// Optional: define PUF_CRP_UNSTABLE_MASK_EN to add the unstable_mask/unstable_cnt outputs.
module puf_crp_sampler #(
  parameter int unsigned CHAL_W        = 120,
  parameter int unsigned RESP_W        = 120,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLES       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [1:0]        user_cfg,
  output logic [CHAL_W-1:0] puf_chal,
  output logic [1:0]        puf_user,
  output logic              puf_enable,
  input  logic [RESP_W-1:0] puf_resp,
  output logic [RESP_W-1:0] resp_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy
`ifdef PUF_CRP_UNSTABLE_MASK_EN
  ,
  output logic [RESP_W-1:0] unstable_mask,
  output logic [7:0]        unstable_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_VOTE,
    S_OUT
  } state_t;

  state_t              state, state_d;
  logic [7:0]          settle_cnt;
  logic [3:0]          samp_cnt;
  logic [3:0]          ones [RESP_W];
  logic                accept, sample_en, vote_en, out_done;
  logic [RESP_W-1:0]   vote;

  // Gated with reset so the block never advertises readiness while held in reset.
  assign chal_ready = (state == S_IDLE) && reset;
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    sample_en = 1'b0;
    vote_en   = 1'b0;
    out_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (chal_valid) begin
          accept  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        if (samp_cnt == 4'(SAMPLES - 1)) state_d = S_VOTE;
      end
      S_VOTE: begin
        vote_en = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (resp_ready) begin
          out_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vote = '0;
    for (int unsigned b = 0; b < RESP_W; b++) begin
      vote[b] = (ones[b] > 4'(SAMPLES / 2));
    end
  end

`ifdef PUF_CRP_UNSTABLE_MASK_EN
  logic [RESP_W-1:0] mask_d;
  logic [15:0]       pop;
  logic [7:0]        pop_sat;

  always_comb begin
    mask_d = '0;
    pop    = '0;
    for (int unsigned b = 0; b < RESP_W; b++) begin
      mask_d[b] = (ones[b] != '0) && (ones[b] < 4'(SAMPLES));
      pop       = pop + 16'(mask_d[b]);
    end
    pop_sat = (pop > 16'd255) ? 8'hFF : pop[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unstable_mask <= '0;
      unstable_cnt  <= '0;
    end else if (vote_en) begin
      unstable_mask <= mask_d;
      unstable_cnt  <= pop_sat;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      puf_chal   <= '0;
      puf_user   <= '0;
      puf_enable <= 1'b0;
      resp_out   <= '0;
      resp_valid <= 1'b0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      for (int unsigned b = 0; b < RESP_W; b++) ones[b] <= '0;
    end else begin
      if (accept) begin
        puf_chal   <= chal_in;
        puf_user   <= user_cfg;
        puf_enable <= 1'b1;
        settle_cnt <= 8'(SETTLE_CYCLES - 1);
        samp_cnt   <= '0;
        for (int unsigned b = 0; b < RESP_W; b++) ones[b] <= '0;
      end
      if (state == S_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
      if (sample_en) begin
        samp_cnt <= samp_cnt + 4'd1;
        for (int unsigned b = 0; b < RESP_W; b++) ones[b] <= ones[b] + {3'b000, puf_resp[b]};
      end
      if (vote_en) begin
        resp_out   <= vote;
        resp_valid <= 1'b1;
        puf_enable <= 1'b0;
      end
      if (out_done) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_crp_sampler.sv
// Directed self-checking bench for puf_crp_sampler (default 16/5 instance plus a 1/1 boundary instance).
// Also checks unstable_mask/unstable_cnt when PUF_CRP_UNSTABLE_MASK_EN is defined.
module tb_puf_crp_sampler;
  localparam int unsigned W = 120;

  logic         clk = 1'b0;
  logic         reset;
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] chal_in, puf_chal, puf_resp, resp_out;
  logic         chal_valid, chal_ready, puf_enable, resp_valid, resp_ready, busy;
  logic [1:0]   user_cfg, puf_user;

  logic [W-1:0] chal_in1, puf_chal1, puf_resp1, resp_out1;
  logic         chal_valid1, chal_ready1, puf_enable1, resp_valid1, resp_ready1, busy1;
  logic [1:0]   user_cfg1, puf_user1;

`ifdef PUF_CRP_UNSTABLE_MASK_EN
  logic [W-1:0] unstable_mask, unstable_mask1;
  logic [7:0]   unstable_cnt, unstable_cnt1;
`endif

  always #5 clk = ~clk;

  puf_crp_sampler #(.CHAL_W(W), .RESP_W(W), .SETTLE_CYCLES(16), .SAMPLES(5)) dut (
    .clk(clk), .reset(reset), .chal_in(chal_in), .chal_valid(chal_valid), .chal_ready(chal_ready),
    .user_cfg(user_cfg), .puf_chal(puf_chal), .puf_user(puf_user), .puf_enable(puf_enable),
    .puf_resp(puf_resp), .resp_out(resp_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .busy(busy)
`ifdef PUF_CRP_UNSTABLE_MASK_EN
    , .unstable_mask(unstable_mask), .unstable_cnt(unstable_cnt)
`endif
  );

  puf_crp_sampler #(.CHAL_W(W), .RESP_W(W), .SETTLE_CYCLES(1), .SAMPLES(1)) dut1 (
    .clk(clk), .reset(reset), .chal_in(chal_in1), .chal_valid(chal_valid1), .chal_ready(chal_ready1),
    .user_cfg(user_cfg1), .puf_chal(puf_chal1), .puf_user(puf_user1), .puf_enable(puf_enable1),
    .puf_resp(puf_resp1), .resp_out(resp_out1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .busy(busy1)
`ifdef PUF_CRP_UNSTABLE_MASK_EN
    , .unstable_mask(unstable_mask1), .unstable_cnt(unstable_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [W-1:0] c, input logic [1:0] u);
    chal_in    = c;
    user_cfg   = u;
    chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] v);
    puf_resp = v;
    tick();
  endtask

  initial begin
    int n;
    logic ok;
    reset = 1'b1;
    chal_in = '0; chal_valid = 1'b0; user_cfg = '0; puf_resp = '0; resp_ready = 1'b1;
    chal_in1 = '0; chal_valid1 = 1'b0; user_cfg1 = '0; puf_resp1 = '0; resp_ready1 = 1'b1;

    #2 reset = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", puf_enable, 0);
    check("rst_puf_chal", puf_chal, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rel_chal_ready", chal_ready, 1);

    // Stable response and latency
    puf_resp = 120'h3C;
    handshake(120'h0A5, 2'd2);
    check("hs_enable", puf_enable, 1);
    check("hs_user", puf_user, 2);
    check("hs_busy", busy, 1);
    check("hs_chal_ready", chal_ready, 0);
    n = 0; ok = 1'b1;
    while (resp_valid !== 1'b1 && n < 60) begin
      tick(); n++;
      if (puf_chal !== 120'h0A5) ok = 1'b0;
    end
    check("stable_latency", n, 22);
    check("stable_chal_held", ok, 1);
    check("stable_resp", resp_out, 120'h3C);
    check("stable_enable_off", puf_enable, 0);
    tick();
    check("stable_valid_drop", resp_valid, 0);
    check("stable_idle_ready", chal_ready, 1);
    check("stable_resp_kept", resp_out, 120'h3C);

    // Majority 1,0,1,0,1 on bit 7 with backpressure
    resp_ready = 1'b0;
    handshake(120'h55, 2'd1);
    repeat (16) tick();
    feed(120'h80); feed(120'h00); feed(120'h80); feed(120'h00); feed(120'h80);
    tick();
    check("maj1_valid", resp_valid, 1);
    check("maj1_resp", resp_out, 120'h80);
`ifdef PUF_CRP_UNSTABLE_MASK_EN
    check("maj1_mask", unstable_mask, 120'h80);
    check("maj1_ucnt", unstable_cnt, 1);
`endif
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chal_valid = i[0];
      chal_in    = 120'hDEAD;
      tick();
      if (resp_valid !== 1'b1 || resp_out !== 120'h80 || chal_ready !== 1'b0 || puf_chal !== 120'h55)
        ok = 1'b0;
    end
    chal_valid = 1'b0;
    check("bp_stable", ok, 1);
    resp_ready = 1'b1;
    tick();
    check("bp_release_valid", resp_valid, 0);
    check("bp_release_busy", busy, 0);
    check("bp_release_ready", chal_ready, 1);
    check("bp_chal_kept", puf_chal, 120'h55);

    // Majority 0,1,0,0,1 on bit 7, next challenge queued
    handshake(120'h77, 2'd0);
    chal_valid = 1'b1;
    chal_in    = 120'h1;
    repeat (16) tick();
    feed(120'h01); feed(120'h81); feed(120'h01); feed(120'h01); feed(120'h81);
    tick();
    check("maj2_valid", resp_valid, 1);
    check("maj2_resp", resp_out, 120'h01);
    check("maj2_chal_ignored", puf_chal, 120'h77);
`ifdef PUF_CRP_UNSTABLE_MASK_EN
    check("maj2_mask", unstable_mask, 120'h80);
    check("maj2_ucnt", unstable_cnt, 1);
`endif
    puf_resp = 120'hF0;
    tick();
    check("b2b_ready", chal_ready, 1);
    check("b2b_valid_drop", resp_valid, 0);
    tick();
    chal_valid = 1'b0;
    check("b2b_chal", puf_chal, 120'h1);
    check("b2b_busy", busy, 1);
    check("b2b_enable", puf_enable, 1);
    n = 0;
    while (resp_valid !== 1'b1 && n < 60) begin
      tick(); n++;
    end
    check("b2b_latency", n, 22);
    check("b2b_resp", resp_out, 120'hF0);
    tick();

    // Reset mid-SAMPLE
    handshake(120'h3, 2'd0);
    puf_resp = 120'hFF;
    repeat (18) tick();
    check("mid_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_enable", puf_enable, 0);
    check("mid_rst_chal", puf_chal, 0);
    check("mid_rst_resp", resp_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", chal_ready, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("mid_rel_ready", chal_ready, 1);
    ok = 1'b0;
    repeat (30) begin
      tick();
      if (resp_valid !== 1'b0) ok = 1'b1;
    end
    check("mid_no_pulse", ok, 0);

    // Boundary instance: SETTLE_CYCLES=1, SAMPLES=1
    puf_resp1   = 120'hAAA;
    chal_in1    = 120'h9;
    chal_valid1 = 1'b1;
    tick();
    chal_valid1 = 1'b0;
    check("b1_busy", busy1, 1);
    check("b1_valid0", resp_valid1, 0);
    tick();
    check("b1_valid1", resp_valid1, 0);
    tick();
    puf_resp1 = 120'h555;
    check("b1_valid2", resp_valid1, 0);
    tick();
    check("b1_valid3", resp_valid1, 1);
    check("b1_resp", resp_out1, 120'hAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
